adder_resp_checker: RTL and testbench

Synthesizable response checker for the half-adder datapath: the receiving end of the half-adder stimulus stream. It accepts one vector per handshake ({a, b} plus the DUT's {s, c}), computes the expected sum and carry, and keeps pass/fail counts. It latches the first mismatching vector and signals completion after a programmed number of vectors. It lets on-chip or bench-driven stimulus be checked without `$monitor` inspection.

---
 rtl/adder_resp_checker.sv | 100 ++++++++++
 tb/tb_adder_resp_checker.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/adder_resp_checker.sv
// adder_resp_checker: half-adder response checker with pass/fail counts and first-mismatch capture
// CHECK_TIMEOUT_EN builds an idle watchdog that ends a stalled run with timeout set.
module adder_resp_checker #(
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             s,
    input  logic             c,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [3:0]       first_fail_vec,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
    localparam logic [CNT_W-1:0] ONE = 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] idx;
    logic accept, match, last, wd_hit, restart;

    assign in_ready = state == CHECK;
    assign busy = state == CHECK;
    assign done = state == DONE;
    assign accept = in_valid & in_ready;
    assign match = (s == (a ^ b)) && (c == (a & b));
    assign last = accept && idx == LAST_IDX;
    assign restart = start && state != CHECK;

`ifdef CHECK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd;
    assign wd_hit = state == CHECK && !accept && wd == WD_LAST;
    // wd is held at zero outside CHECK, so entering CHECK always starts a fresh count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd <= '0;
            timeout <= 1'b0;
        end else begin
            wd <= (state != CHECK || accept) ? '0 : wd + 1'b1;
            timeout <= restart ? 1'b0 : (wd_hit ? 1'b1 : timeout);
        end
    end
`else
    assign wd_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = state == CHECK ? ((last || wd_hit) ? DONE : CHECK) : (start ? CHECK : state);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            err <= 1'b0;
            first_fail_vec <= '0;
            first_fail_idx <= '0;
        end else if (restart) begin
            idx <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            err <= 1'b0;
            first_fail_vec <= '0;
            first_fail_idx <= '0;
        end else if (accept) begin
            idx <= idx + ONE;
            if (match) begin
                if (~&pass_cnt) pass_cnt <= pass_cnt + ONE;
            end else begin
                if (~&fail_cnt) fail_cnt <= fail_cnt + ONE;
                err <= 1'b1;
                if (!err) begin
                    first_fail_vec <= {a, b, s, c};
                    first_fail_idx <= idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_resp_checker.sv
// tb_adder_resp_checker: directed scoreboard bench for adder_resp_checker
module tb_adder_resp_checker;
    localparam int N = 4;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic a = 1'b0, b = 1'b0, s = 1'b0, c = 1'b0;
    logic in_ready, busy, done, err, timeout;
    logic [7:0] pass_cnt, fail_cnt, first_fail_idx;
    logic [3:0] first_fail_vec;
    int total = 0, passed = 0;
    int m_pass, m_fail, m_idx, m_fidx;
    bit m_err;
    logic [3:0] m_fvec;
    logic [4:0] sb[$];

    adder_resp_checker #(.NUM_VECTORS(N), .CNT_W(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .s(s), .c(c), .busy(busy), .done(done), .err(err),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_vec(first_fail_vec),
        .first_fail_idx(first_fail_idx), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_pass = 0; m_fail = 0; m_idx = 0; m_fidx = 0; m_err = 0; m_fvec = '0;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_pass"}, 64'(pass_cnt), 64'(m_pass));
        chk({tag, "_fail"}, 64'(fail_cnt), 64'(m_fail));
        chk({tag, "_err"}, 64'(err), 64'(m_err));
    endtask

    // called #1 after a clock edge; leaves time at #1 after the next edge
    task automatic pulse_start(input bit restarts);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (restarts) model_clear();
        chk("start_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic send(input bit va, input bit vb, input bit vs, input bit vc);
        logic [4:0] e;
        bit ok;
        a = va; b = vb; s = vs; c = vc; in_valid = 1'b1;
        sb.push_back({(vs == (va ^ vb)) && (vc == (va & vb)), va, vb, vs, vc});
        chk("ready_before_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = sb.pop_front();
        ok = e[4];
        if (ok) m_pass++;
        else begin
            m_fail++;
            if (!m_err) begin m_fvec = e[3:0]; m_fidx = m_idx; end
            m_err = 1;
        end
        m_idx++;
        check_counts("vec");
        chk("done_after_vec", 64'(done), 64'(m_idx == N));
    endtask

    task automatic idle_valid(input int n, input string tag);
        a = 1'b1; b = 1'b1; s = 1'b0; c = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_counts(tag);
    endtask

    task automatic send_good4();
        send(0, 0, 0, 0); send(0, 1, 1, 0); send(1, 0, 1, 0); send(1, 1, 0, 1);
    endtask

    initial begin
        int n;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_outs", {in_ready, busy, done, err, timeout, pass_cnt, fail_cnt, first_fail_vec, first_fail_idx}, 64'd0);
        idle_valid(4, "idle_valid");
        chk("idle_state", {busy, done}, 64'd0);

        pulse_start(1);
        chk("busy_check", 64'(busy), 64'd1);
        send_good4();
`ifndef CHECK_TIMEOUT_EN
        chk("timeout_tied", 64'(timeout), 64'd0);
`endif
        idle_valid(4, "done_valid");
        chk("done_hold", 64'(done), 64'd1);

        pulse_start(1);
        check_counts("restart_clear");
        send(0, 0, 0, 0); send(0, 1, 1, 0); send(1, 0, 0, 0); send(1, 1, 0, 1);
        chk("ffvec_last3", 64'(first_fail_vec), 64'(m_fvec));
        chk("ffvec_1000", 64'(first_fail_vec), 64'b1000);
        chk("ffidx_2", 64'(first_fail_idx), 64'd2);

        pulse_start(1);
        send(0, 0, 0, 0); send(0, 1, 1, 1); send(1, 0, 1, 0); send(1, 1, 1, 1);
        chk("ffvec_0111", 64'(first_fail_vec), 64'b0111);
        chk("ffidx_1", 64'(first_fail_idx), 64'(m_fidx));
        chk("fail_2", 64'(fail_cnt), 64'd2);

        pulse_start(1);
        send(0, 0, 0, 0); send(1, 1, 0, 1);
        pulse_start(0);
        chk("mid_start_busy", 64'(busy), 64'd1);
        check_counts("mid_start");
        send(0, 1, 1, 0); send(1, 0, 1, 0);
        chk("mid_start_pass4", 64'(pass_cnt), 64'd4);

        pulse_start(1);
        send(0, 0, 0, 1); send(1, 1, 0, 1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_outs", {in_ready, busy, done, err, timeout, pass_cnt, fail_cnt, first_fail_vec, first_fail_idx}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        model_clear();
        sb.delete();
        chk("rst_idle", {busy, done, in_ready}, 64'd0);
        pulse_start(1);
        send_good4();
        chk("post_rst_pass4", 64'(pass_cnt), 64'd4);

`ifdef CHECK_TIMEOUT_EN
        pulse_start(1);
        send(1, 1, 0, 1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'd16);
        chk("timeout_flag", {timeout, done}, 64'b11);
        chk("timeout_pass1", 64'(pass_cnt), 64'd1);
        chk("timeout_err", 64'(err), 64'd0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
